mem_access_ctrl: RTL and testbench

//   Sequences the single shared memory port of the multicycle processor.

---
 rtl/mem_access_ctrl_if.sv | 43 ++++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of requester-side and memory-side signals of the shared memory port.
//   master : the access controller (drives acks, held read data, memory strobe/address/data)
//   slave  : the requesters and the memory (drive requests, addresses, mem_rdata, mem_ready)
// Signals:
//   if_req/if_addr/if_ack/if_rdata             instruction-fetch requester
//   ls_req/ls_we/ls_addr/ls_wdata/ls_ack/ls_rdata  load/store requester
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready  memory handshake
//   bus_err                                    access timed out (pulses with the ack)
interface mem_access_ctrl_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          bus_err;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, ls_ack, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, ls_ack, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer for the single shared memory port of the multicycle processor.
// Arbitrates round-robin between instruction fetch (IF) and load/store (LS), runs one
// IDLE -> ACCESS -> RESP transaction at a time, and keeps the last word read by each
// requester in a held register (IR side: if_rdata, MDR side: ls_rdata).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any transaction in flight
//   bus    mem_access_ctrl_if.master (requester handshakes and memory handshake)
// Parameters:
//   AW, DW   address / data width
//   TIMEOUT  ACCESS cycles without mem_ready before a bus error; 0 disables the timeout
module mem_access_ctrl #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_ctrl_if.master bus
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned    CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CntLast = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic {GntLs, GntIf} gnt_e;

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;      // owner of the current / most recent transaction
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          ls_ack_q, ls_ack_d;
  logic          bus_err_q, bus_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;

  logic grant_if;
  logic finish;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    grant_if    = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.ls_req) begin
          // On a tie the requester that did not go last wins.
          grant_if    = bus.if_req && (!bus.ls_req || (gnt_q == GntLs));
          gnt_d       = grant_if ? GntIf : GntLs;
          mem_addr_d  = grant_if ? bus.if_addr : bus.ls_addr;
          mem_we_d    = !grant_if && bus.ls_we;
          mem_wdata_d = grant_if ? '0 : bus.ls_wdata;
          mem_en_d    = 1'b1;
          cnt_d       = '0;
          state_d     = StAccess;
        end
      end

      StAccess: begin
        // mem_ready wins over a timeout in the same cycle.
        if (bus.mem_ready) begin
          finish = 1'b1;
          if (!mem_we_q) begin
            if (gnt_q == GntIf) if_rdata_d = bus.mem_rdata;
            else                ls_rdata_d = bus.mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          finish    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (finish) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if_ack_d = (gnt_q == GntIf);
          ls_ack_d = (gnt_q == GntLs);
          state_d  = StResp;
        end
      end

      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= GntLs;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: scoreboard of expected transactions, one task per scenario.
module tb_mem_access_ctrl;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_if;
    bit          we;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
    logic [31:0] if_rd;
    logic [31:0] ls_rd;
  } exp_t;

  typedef struct {
    bit          if_ack;
    bit          ls_ack;
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
    int          lat;
    bit          stable;
    bit          en_resp;
    logic [31:0] if_rd;
    logic [31:0] ls_rd;
  } obs_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_if_rd;
  logic [31:0] m_ls_rd;
  bit          m_last_if;
  exp_t        e;
  obs_t        o;

  function automatic logic [141:0] pack_exp(input exp_t x);
    return {x.is_if, !x.is_if, x.err, x.we, x.addr, (x.we ? x.wdata : 32'h0), 8'(x.cycles),
            1'b1, 1'b0, x.if_rd, x.ls_rd};
  endfunction

  function automatic logic [141:0] pack_obs(input obs_t x);
    return {x.if_ack, x.ls_ack, x.err, x.we, x.addr, (x.we ? x.wdata : 32'h0), 8'(x.cycles),
            x.stable, x.en_resp, x.if_rd, x.ls_rd};
  endfunction

  // Expected outcome of a transaction, with the held read registers predicted from history.
  task automatic push_exp(input bit is_if, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input bit err,
                          input int cycles);
    exp_t x;
    if (!we && !err) begin
      if (is_if) m_if_rd = rdata;
      else       m_ls_rd = rdata;
    end
    m_last_if = is_if;
    x.is_if  = is_if;
    x.we     = we;
    x.err    = err;
    x.addr   = addr;
    x.wdata  = wdata;
    x.cycles = cycles;
    x.if_rd  = m_if_rd;
    x.ls_rd  = m_ls_rd;
    sb.push_back(x);
  endtask

  task automatic idle_bus();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_bus();
    m_if_rd   = '0;
    m_ls_rd   = '0;
    m_last_if = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Memory side of one transaction: waits for the grant, answers after 'waits' ACCESS cycles
  // (-1: never), returns what it saw in the RESP cycle. Drops the requests unless keep_req.
  task automatic serve(input int waits, input logic [31:0] rdata, input bit keep_req,
                       input bit scramble, output obs_t ob);
    ob.if_ack = 0; ob.ls_ack = 0; ob.err = 0; ob.we = 0; ob.addr = '0; ob.wdata = '0;
    ob.cycles = 0; ob.lat = 0; ob.stable = 0; ob.en_resp = 1; ob.if_rd = '0; ob.ls_rd = '0;
    while (!bus.mem_en && ob.lat < 8) begin
      @(posedge clk);
      #1;
      ob.lat++;
    end
    if (!bus.mem_en) return;
    ob.addr   = bus.mem_addr;
    ob.we     = bus.mem_we;
    ob.wdata  = bus.mem_wdata;
    ob.stable = 1'b1;
    if (scramble) begin
      bus.if_addr  = ~bus.if_addr;
      bus.ls_addr  = ~bus.ls_addr;
      bus.ls_wdata = ~bus.ls_wdata;
      bus.ls_we    = ~bus.ls_we;
    end
    while (!(bus.if_ack || bus.ls_ack) && ob.cycles < 40) begin
      if (!bus.mem_en || bus.mem_addr !== ob.addr || bus.mem_we !== ob.we ||
          bus.mem_wdata !== ob.wdata) ob.stable = 1'b0;
      bus.mem_ready = (ob.cycles == waits);
      bus.mem_rdata = (ob.cycles == waits) ? rdata : ~rdata;
      @(posedge clk);
      #1;
      ob.cycles++;
      bus.mem_ready = 1'b0;
    end
    ob.if_ack  = bus.if_ack;
    ob.ls_ack  = bus.ls_ack;
    ob.err     = bus.bus_err;
    ob.en_resp = bus.mem_en;
    ob.if_rd   = bus.if_rdata;
    ob.ls_rd   = bus.ls_rdata;
    // mem_ready in RESP must be ignored.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    if (!keep_req) begin
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_assert++;
    if (bus.mem_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en);
    end
    n_assert++;
    if (bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we);
    end
    n_assert++;
    if (bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr);
    end
    n_assert++;
    if (bus.mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata);
    end
    n_assert++;
    if ({bus.if_ack, bus.ls_ack, bus.bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_acks: got %b want 000", {bus.if_ack, bus.ls_ack, bus.bus_err});
    end
    n_assert++;
    if (bus.if_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata);
    end
    n_assert++;
    if (bus.ls_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_ls_rdata: got %h want 0", bus.ls_rdata);
    end
    // mem_ready with no request pending does nothing.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1357_9BDF;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({bus.if_ack, bus.ls_ack, bus.mem_en, bus.if_rdata, bus.ls_rdata} !== 67'h0) begin
      n_fail++;
      $display("FAIL idle_ready_ignored: got ack=%b%b en=%b if=%h ls=%h want all 0",
               bus.if_ack, bus.ls_ack, bus.mem_en, bus.if_rdata, bus.ls_rdata);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_if_read();
    bus.if_addr = 32'h0000_0010;
    bus.if_req  = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h8C22_0004, 1'b0, 1);
    serve(0, 32'h8C22_0004, 1'b0, 1'b1, o);
    n_assert++;
    if (o.lat != 1) begin
      n_fail++; $display("FAIL if_read_latency: got %0d cycles want 1", o.lat);
    end
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL if_read_sb: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (pack_obs(o) !== pack_exp(e)) begin
        n_fail++; $display("FAIL if_read_txn: got %h want %h", pack_obs(o), pack_exp(e));
      end
    end
    next_cycle();
    n_assert++;
    if ({bus.if_ack, bus.ls_ack, bus.bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL if_read_pulse: got %b want 000", {bus.if_ack, bus.ls_ack, bus.bus_err});
    end
  endtask

  // A load then a store: the store must leave the loaded MDR value alone.
  task automatic test_ls_store();
    logic [31:0] addr_tbl [2];
    logic [31:0] data_tbl [2];
    bit          we_tbl   [2];
    int          wait_tbl [2];
    addr_tbl = '{32'h44, 32'h40};
    data_tbl = '{32'h1234_5678, 32'hA5A5_A5A5};
    we_tbl   = '{1'b0, 1'b1};
    wait_tbl = '{1, 3};
    for (int i = 0; i < 2; i++) begin
      bus.ls_addr  = addr_tbl[i];
      bus.ls_we    = we_tbl[i];
      bus.ls_wdata = we_tbl[i] ? data_tbl[i] : 32'h0;
      bus.ls_req   = 1'b1;
      push_exp(1'b0, we_tbl[i], addr_tbl[i], data_tbl[i], data_tbl[i], 1'b0, wait_tbl[i] + 1);
      // On the store the memory still presents junk read data.
      serve(wait_tbl[i], we_tbl[i] ? 32'hDEAD_BEEF : data_tbl[i], 1'b0, 1'b1, o);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL ls_txn%0d_sb: got empty scoreboard want 1 entry", i);
      end else begin
        e = sb.pop_front();
        if (pack_obs(o) !== pack_exp(e)) begin
          n_fail++; $display("FAIL ls_txn%0d: got %h want %h", i, pack_obs(o), pack_exp(e));
        end
      end
      next_cycle();
      n_assert++;
      if ({bus.if_ack, bus.ls_ack, bus.bus_err, bus.mem_we} !== 4'b0000) begin
        n_fail++;
        $display("FAIL ls_txn%0d_pulse: got %b want 0000", i,
                 {bus.if_ack, bus.ls_ack, bus.bus_err, bus.mem_we});
      end
    end
  endtask

  // Timeout, ready on the very last allowed cycle, and a normal read after the error.
  task automatic test_timeout();
    int          wait_tbl [3];
    bit          if_tbl   [3];
    logic [31:0] data_tbl [3];
    wait_tbl = '{-1, 15, 5};
    if_tbl   = '{1'b0, 1'b0, 1'b1};
    data_tbl = '{32'hFFFF_0000, 32'h7777_1111, 32'h0BAD_F00D};
    for (int i = 0; i < 3; i++) begin
      bus.ls_we   = 1'b0;
      bus.ls_addr = 32'h80 + 32'(i * 4);
      bus.if_addr = 32'h20 + 32'(i * 4);
      if (if_tbl[i]) bus.if_req = 1'b1;
      else           bus.ls_req = 1'b1;
      push_exp(if_tbl[i], 1'b0, if_tbl[i] ? 32'h20 + 32'(i * 4) : 32'h80 + 32'(i * 4), 32'h0,
               data_tbl[i], (wait_tbl[i] < 0), (wait_tbl[i] < 0) ? int'(TIMEOUT) : wait_tbl[i] + 1);
      serve(wait_tbl[i], data_tbl[i], 1'b0, 1'b0, o);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL timeout%0d_sb: got empty scoreboard want 1 entry", i);
      end else begin
        e = sb.pop_front();
        if (pack_obs(o) !== pack_exp(e)) begin
          n_fail++; $display("FAIL timeout%0d_txn: got %h want %h", i, pack_obs(o), pack_exp(e));
        end
      end
      next_cycle();
      n_assert++;
      if ({bus.if_ack, bus.ls_ack, bus.bus_err} !== 3'b000) begin
        n_fail++;
        $display("FAIL timeout%0d_pulse: got %b want 000", i, {bus.if_ack, bus.ls_ack, bus.bus_err});
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.if_addr = 32'h100;
    bus.ls_addr = 32'h200;
    bus.ls_we   = 1'b0;
    bus.if_req  = 1'b1;
    bus.ls_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(!m_last_if, 1'b0, !m_last_if ? 32'h100 : 32'h200, 32'h0, 32'h1000_0000 + 32'(k),
               1'b0, 1);
      serve(0, 32'h1000_0000 + 32'(k), (k < 3), 1'b0, o);
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL rr%0d_sb: got empty scoreboard want 1 entry", k);
      end else begin
        e = sb.pop_front();
        if (pack_obs(o) !== pack_exp(e)) begin
          n_fail++; $display("FAIL rr%0d_txn: got %h want %h", k, pack_obs(o), pack_exp(e));
        end
      end
      next_cycle();
      n_assert++;
      if ({bus.if_ack, bus.ls_ack, bus.mem_en} !== 3'b000) begin
        n_fail++; $display("FAIL rr%0d_idle: got %b want 000", k, {bus.if_ack, bus.ls_ack, bus.mem_en});
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bus.if_addr = 32'h300;
    bus.if_req  = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.mem_en !== 1'b1) begin
      n_fail++; $display("FAIL midrst_access: got mem_en=%b want 1", bus.mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (bus.mem_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got mem_en=%b want 0", bus.mem_en);
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({bus.if_ack, bus.ls_ack, bus.bus_err, bus.mem_en, bus.if_rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL midrst_no_ack: got ack=%b%b err=%b en=%b if=%h want all 0",
               bus.if_ack, bus.ls_ack, bus.bus_err, bus.mem_en, bus.if_rdata);
    end
    rst_n         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    m_if_rd   = '0;
    m_ls_rd   = '0;
    m_last_if = 1'b0;
    sb.delete();
    bus.ls_addr = 32'h304;
    bus.ls_we   = 1'b0;
    bus.ls_req  = 1'b1;
    push_exp(1'b0, 1'b0, 32'h304, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
    serve(1, 32'hCAFE_F00D, 1'b0, 1'b0, o);
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL midrst_after_sb: got empty scoreboard want 1 entry");
    end else begin
      e = sb.pop_front();
      if (pack_obs(o) !== pack_exp(e)) begin
        n_fail++; $display("FAIL midrst_after_txn: got %h want %h", pack_obs(o), pack_exp(e));
      end
    end
    next_cycle();
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_if_read();
    test_ls_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drained: got %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units want earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
